demux1x8_4bit_reg: RTL



---
 rtl/demux1x8_4bit_reg_pkg.sv | 23 ++
 rtl/demux1x8_4bit_reg_decoder3x8.sv | 18 +
 rtl/demux1x8_4bit_reg.sv | 126 ++++++++++++
 3 files changed

// File: rtl/demux1x8_4bit_reg_pkg.sv
// Shared constants for the registered 1-to-8 4-bit distributor: widths, FSM codes
// and lane indices matching the 8:1 select mux encoding.
package demux1x8_4bit_reg_pkg;

    localparam int WIDTH = 4;
    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] LANE_A = 3'd0;
    localparam logic [SEL_W-1:0] LANE_B = 3'd1;
    localparam logic [SEL_W-1:0] LANE_C = 3'd2;
    localparam logic [SEL_W-1:0] LANE_D = 3'd3;
    localparam logic [SEL_W-1:0] LANE_E = 3'd4;
    localparam logic [SEL_W-1:0] LANE_F = 3'd5;
    localparam logic [SEL_W-1:0] LANE_G = 3'd6;
    localparam logic [SEL_W-1:0] LANE_H = 3'd7;

endpackage

// File: rtl/demux1x8_4bit_reg_decoder3x8.sv
// Combinational 3-to-8 one-hot decoder with enable; yields per-lane write enables.
module decoder3x8
    import demux1x8_4bit_reg_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] idx,
    output logic [LANES-1:0] onehot
);

    always_comb begin
        // NOTE: default-assign every combinational output first so no latch is inferred.
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1x8_4bit_reg.sv
// Registered 1-to-8 distributor for 4-bit write beats, addressed directly by sel
// or by an auto-incrementing burst pointer.
module demux1x8_4bit_reg
    import demux1x8_4bit_reg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] sel,
    input  logic             burst,
    input  logic [SEL_W-1:0] burst_len,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [LANES-1:0] lane_we,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [LANES-1:0] lane_we_q;
    logic [LANES-1:0] dec_we;
    logic [SEL_W-1:0] idx;
    logic             accept;
    logic [WIDTH-1:0] lane_q [LANES];
    logic [WIDTH-1:0] lane_d [LANES];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            lane_we_q <= '0;
            // NOTE: lanes are discrete flops, not a RAM, so they take the reset like any other state.
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            lane_we_q <= dec_we;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            rem_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (burst) begin
                        ptr_d = sel + SEL_W'(1);
                        rem_d = burst_len;
                        if (burst_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    ptr_d = ptr_q + SEL_W'(1);
                    rem_d = rem_q - SEL_W'(1);
                    // rem counts beats still owed after the current one
                    if (rem_q == SEL_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ready = ~clr;
        accept   = wr_valid & ~clr;
        idx      = (state_q == ST_BURST) ? ptr_q : sel;
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = clr ? '0 : (dec_we[i] ? din : lane_q[i]);
        end
    end

    decoder3x8 u_decoder (
        .en     (accept),
        .idx    (idx),
        .onehot (dec_we)
    );

    assign a       = lane_q[LANE_A];
    assign b       = lane_q[LANE_B];
    assign c       = lane_q[LANE_C];
    assign d       = lane_q[LANE_D];
    assign e       = lane_q[LANE_E];
    assign f       = lane_q[LANE_F];
    assign g       = lane_q[LANE_G];
    assign h       = lane_q[LANE_H];
    assign lane_we = lane_we_q;
    assign busy    = (state_q == ST_BURST);
    assign done    = done_q;

endmodule
